// File: rtl/mem_arbiter_pkg.sv
// Shared CPU definitions: opcode constants, memory-arbiter FSM encodings,
// owner encoding and the default memory latency.
package mem_arbiter_pkg;

    // ------------------------------------------------------------------
    // Opcode constants (RV32I major opcodes used by the pipeline decoder)
    // ------------------------------------------------------------------
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ------------------------------------------------------------------
    // Memory arbiter
    // ------------------------------------------------------------------
    // Default number of cycles mem_en stays high for one access (1..15).
    localparam int MEM_LAT_DEFAULT = 2;

    // Width of the latency down-counter; covers the full 1..15 range.
    localparam int CNT_W = 4;

    // Arbiter FSM encodings. IDLE is all-zero so the reset state reads 0.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    // Which pipeline stage owns the access in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    // Counter preload for a given latency: the last access cycle is the
    // one in which the counter reads zero.
    function automatic logic [CNT_W-1:0] lat_load_val(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Latency down-counter for the memory arbiter: loaded at grant, counts
// down once per access cycle, flags zero in the last access cycle.
module mem_wait_counter
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority over decrement; the counter never wraps below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter between the fetch stage (IF) and the
// MEM stage (DM). Data requests win over fetches. One access at a time:
// IDLE (grant) -> ACCESS (MEM_LAT cycles of mem_en) -> DONE (ack pulse).
//
// Handshake: a requester raises its request with address/data and holds it
// until its ack pulse. The request is sampled only in IDLE; address, data
// and direction are latched at the grant edge and everything that changes
// on the request inputs afterwards is ignored. The ack is a one-cycle pulse
// in DONE; the registered rdata is valid from that cycle and holds until
// the next completed read on the same port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    // fetch stage
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    // MEM stage
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    // memory
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // pipeline control
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err,
    // debug: current FSM state encoding
    output logic [1:0]        o_dbg_state
);

    localparam logic [CNT_W-1:0] LP_CNT_LOAD = lat_load_val(MEM_LAT);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    arb_owner_t        r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_err;

    logic w_dm_req;
    logic w_grant;
    logic w_grant_dm;
    logic w_cnt_dec;
    logic w_cnt_zero;
    logic w_capture;
    logic w_in_access;
    logic w_in_done;

    assign w_dm_req = dm_read | dm_write;

    // Latency counter: preloaded at grant, decremented through ACCESS.
    mem_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_grant),
        .i_load_val (LP_CNT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and control decode; data requests take priority.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_dm   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_capture    = 1'b0;
        w_in_access  = 1'b0;
        w_in_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_dm_req) begin
                    w_grant      = 1'b1;
                    w_grant_dm   = 1'b1;
                    w_next_state = ST_ACCESS;
                end else if (if_req) begin
                    w_grant      = 1'b1;
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_in_access = 1'b1;
                if (w_cnt_zero) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DONE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                w_in_done    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Latch the granted request; a simultaneous load+store is done as a store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_grant) begin
            if (w_grant_dm) begin
                r_owner <= OWN_DM;
                r_addr  <= dm_addr;
                r_we    <= dm_write;
                r_wdata <= dm_wdata;
            end else begin
                r_owner <= OWN_IF;
                r_addr  <= if_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
            end
        end
    end

    // Sticky protocol error: load and store requested together at a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_grant_dm && dm_read && dm_write) begin
            r_err <= 1'b1;
        end
    end

    // Capture read data into the owner's register in the last access cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else if (w_capture && !r_we) begin
            if (r_owner == OWN_DM) begin
                r_dm_rdata <= mem_rdata;
            end else begin
                r_if_rdata <= mem_rdata;
            end
        end
    end

    // Memory drive comes from the latched request only.
    assign mem_en    = w_in_access;
    assign mem_we    = w_in_access & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_ack    = w_in_done & (r_owner == OWN_IF);
    assign dm_ack    = w_in_done & (r_owner == OWN_DM);
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign err       = r_err;

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = w_dm_req & ~dm_ack;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT (MEM_LAT = 2) ----------------
    logic          if_req, if_ack, dm_read, dm_write, dm_ack;
    logic [AW-1:0] if_addr, dm_addr, mem_addr;
    logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
    logic          mem_en, mem_we, stall_if, stall_mem, err;
    logic [1:0]    dbg_state;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err), .o_dbg_state(dbg_state)
    );

    // ---------------- second DUT (MEM_LAT = 1) ----------------
    logic          b_if_req, b_if_ack, b_dm_read, b_dm_write, b_dm_ack;
    logic [AW-1:0] b_if_addr, b_dm_addr, b_mem_addr;
    logic [DW-1:0] b_if_rdata, b_dm_wdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
    logic          b_mem_en, b_mem_we, b_stall_if, b_stall_mem, b_err;
    logic [1:0]    b_dbg_state;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut_lat1 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .dm_read(b_dm_read), .dm_write(b_dm_write), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem), .err(b_err), .o_dbg_state(b_dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_busy counts the remaining cycles of the transaction in flight:
    // LAT+1 .. 2 are memory cycles, 1 is the ack cycle, 0 means free.
    int            m_busy;
    bit            m_own_dm;
    logic [AW-1:0] m_addr;
    bit            m_we;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_if_rdata, m_dm_rdata;
    bit            m_err;
    logic [DW-1:0] exp_q[$];   // read data expected at the next read ack
    bit            last_if_ack, last_dm_ack;

    task automatic model_reset();
        m_busy     = 0;
        m_own_dm   = 0;
        m_addr     = '0;
        m_we       = 0;
        m_wdata    = '0;
        m_if_rdata = '0;
        m_dm_rdata = '0;
        m_err      = 0;
        exp_q.delete();
    endtask

    // One clock cycle: check outputs mid-cycle, advance model over the edge.
    task automatic tick();
        bit e_en, e_if_ack, e_dm_ack;
        logic [DW-1:0] e_rd;
        @(negedge clk);
        e_en     = (m_busy > 1);
        e_if_ack = (m_busy == 1) && !m_own_dm;
        e_dm_ack = (m_busy == 1) && m_own_dm;
        check("mem_en", mem_en, e_en);
        check("mem_we", mem_we, e_en && m_we);
        if (e_en) begin
            check("mem_addr", mem_addr, m_addr);
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
        check("if_ack", if_ack, e_if_ack);
        check("dm_ack", dm_ack, e_dm_ack);
        check("if_rdata", if_rdata, m_if_rdata);
        check("dm_rdata", dm_rdata, m_dm_rdata);
        check("err", err, m_err);
        check("stall_if", stall_if, if_req && !e_if_ack);
        check("stall_mem", stall_mem, (dm_read || dm_write) && !e_dm_ack);
        if (m_busy == 1 && !m_we) begin
            check("rd_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e_rd = exp_q.pop_front();
                check("ack_rdata", m_own_dm ? dm_rdata : if_rdata, e_rd);
            end
        end
        last_if_ack = e_if_ack;
        last_dm_ack = e_dm_ack;
        // rising edge
        if (rst) begin
            model_reset();
        end else if (m_busy == 0) begin
            if (dm_read || dm_write) begin
                m_own_dm = 1;
                m_addr   = dm_addr;
                m_we     = dm_write;
                m_wdata  = dm_wdata;
                if (dm_read && dm_write) m_err = 1;
                m_busy   = LAT + 1;
            end else if (if_req) begin
                m_own_dm = 0;
                m_addr   = if_addr;
                m_we     = 0;
                m_busy   = LAT + 1;
            end
        end else begin
            if (m_busy == 2 && !m_we) begin
                if (m_own_dm) m_dm_rdata = mem_rdata;
                else          m_if_rdata = mem_rdata;
                exp_q.push_back(mem_rdata);
            end
            m_busy--;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        rst = 1'b1;
        if_req = 0; if_addr = '0; dm_read = 0; dm_write = 0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0;
        b_if_req = 0; b_if_addr = '0; b_dm_read = 0; b_dm_write = 0; b_dm_addr = '0;
        b_dm_wdata = '0; b_mem_rdata = '0;
        model_reset();
        last_if_ack = 0; last_dm_ack = 0;

        // reset values, before any clock edge
        #1;
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_dm_ack", dm_ack, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // MEM_LAT=1 fetch: mem_en one cycle, if_ack two cycles after grant
        b_if_req = 1; b_if_addr = '0; b_mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("l1_c1_mem_en", b_mem_en, 1);
        check("l1_c1_mem_addr", b_mem_addr, 0);
        check("l1_c1_if_ack", b_if_ack, 0);
        @(posedge clk); #1;
        check("l1_c2_mem_en", b_mem_en, 0);
        check("l1_c2_if_ack", b_if_ack, 1);
        check("l1_c2_if_rdata", b_if_rdata, 32'hCAFEF00D);
        b_if_req = 0;
        @(posedge clk); #1;
        check("l1_c3_if_ack", b_if_ack, 0);
        check("l1_c3_if_rdata", b_if_rdata, 32'hCAFEF00D);

        // MEM_LAT=2 load from 0x40
        dm_read = 1; dm_addr = 32'h40; mem_rdata = 32'hDEADBEEF;
        tick();
        check("ld_c1_mem_en", mem_en, 1);
        check("ld_c1_mem_addr", mem_addr, 32'h40);
        tick();
        check("ld_c2_mem_en", mem_en, 1);
        check("ld_c2_dm_ack", dm_ack, 0);
        tick();
        check("ld_c3_dm_ack", dm_ack, 1);
        check("ld_c3_mem_en", mem_en, 0);
        check("ld_c3_dm_rdata", dm_rdata, 32'hDEADBEEF);
        dm_read = 0;
        tick();

        // fetch and store together: store first, fetch right after
        if_req = 1; if_addr = 32'h100;
        dm_write = 1; dm_addr = 32'h200; dm_wdata = 32'h12345678;
        mem_rdata = 32'h0BADF00D;
        tick();
        check("wf_c1_mem_we", mem_we, 1);
        check("wf_c1_mem_addr", mem_addr, 32'h200);
        check("wf_c1_mem_wdata", mem_wdata, 32'h12345678);
        check("wf_c1_stall_if", stall_if, 1);
        tick();
        check("wf_c2_stall_if", stall_if, 1);
        tick();
        check("wf_c3_dm_ack", dm_ack, 1);
        check("wf_c3_stall_if", stall_if, 1);
        check("wf_c3_dm_rdata", dm_rdata, 32'hDEADBEEF);
        dm_write = 0;
        tick();
        check("wf_c4_mem_en", mem_en, 0);
        check("wf_c4_stall_if", stall_if, 1);
        tick();
        check("wf_c5_mem_en", mem_en, 1);
        check("wf_c5_mem_addr", mem_addr, 32'h100);
        check("wf_c5_mem_we", mem_we, 0);
        tick();
        tick();
        check("wf_c7_if_ack", if_ack, 1);
        check("wf_c7_stall_if", stall_if, 0);
        check("wf_c7_if_rdata", if_rdata, 32'h0BADF00D);
        if_req = 0;
        tick();

        // load and store together: performed as store, sticky err
        dm_read = 1; dm_write = 1; dm_addr = 32'h80; dm_wdata = 32'hA5A5A5A5;
        mem_rdata = 32'h11112222;
        tick();
        check("both_mem_we", mem_we, 1);
        check("both_err", err, 1);
        tick();
        tick();
        check("both_dm_ack", dm_ack, 1);
        check("both_dm_rdata", dm_rdata, 32'hDEADBEEF);
        dm_read = 0; dm_write = 0;
        repeat (3) tick();
        check("both_err_sticky", err, 1);

        // reset in the second access cycle aborts the load
        dm_read = 1; dm_addr = 32'h44; mem_rdata = 32'h55AA55AA;
        tick();
        tick();
        check("ra_c2_mem_en", mem_en, 1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("ra_mem_en", mem_en, 0);
        check("ra_dm_ack", dm_ack, 0);
        check("ra_err", err, 0);
        check("ra_dm_rdata", dm_rdata, 0);
        tick();
        rst = 1'b0;
        tick();
        check("ra_regrant_mem_en", mem_en, 1);
        check("ra_regrant_addr", mem_addr, 32'h44);
        tick();
        tick();
        check("ra_dm_ack_after", dm_ack, 1);
        check("ra_dm_rdata_after", dm_rdata, 32'h55AA55AA);
        dm_read = 0;
        tick();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            tick();
            mem_rdata = $urandom();
            if (if_req) begin
                if (last_if_ack) if_req = 0;
                else if ($urandom_range(0, 7) == 0) if_addr = $urandom();
            end else if ($urandom_range(0, 2) == 0) begin
                if_req  = 1;
                if_addr = $urandom();
            end
            if (dm_read || dm_write) begin
                if (last_dm_ack) begin
                    dm_read = 0; dm_write = 0;
                end else if ($urandom_range(0, 7) == 0) begin
                    dm_addr = $urandom(); dm_wdata = $urandom();
                end
            end else if ($urandom_range(0, 2) == 0) begin
                k        = $urandom_range(0, 39);
                dm_read  = (k < 20) || (k == 39);
                dm_write = (k >= 20);
                dm_addr  = $urandom();
                dm_wdata = $urandom();
            end
        end
        if_req = 0; dm_read = 0; dm_write = 0;
        repeat (LAT + 3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
